sync_pkt_fifo: RTL and testbench

//  Single-clock, packet-aware FIFO for the Ethernet datapath (MAC rx/tx buffering). Successor to the

---
 rtl/sync_pkt_fifo_pkg.sv | 27 ++
 rtl/sync_pkt_fifo_mem.sv | 44 ++++
 rtl/sync_pkt_fifo.sv | 160 ++++++++++++++++
 tb/tb_sync_pkt_fifo.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkt_fifo_pkg.sv
// Shared definitions for the packet FIFO: drop counter width and pointer compare helpers.
// Pointers are ASIZE+1 bits wide, zero-extended into ptr_t before the helpers are called.
package sync_pkt_fifo_pkg;

    localparam int unsigned DROP_CNT_W = 16;
    localparam int unsigned PTR_MAX_W  = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t ptr_mask(input int unsigned asize);
        return (ptr_t'(1) << (asize + 1)) - ptr_t'(1);
    endfunction

    // Words between tail and head, modulo 2**(asize+1).
    function automatic ptr_t ptr_level(input ptr_t head, input ptr_t tail, input int unsigned asize);
        return (head - tail) & ptr_mask(asize);
    endfunction

    function automatic logic ptr_full(input ptr_t head, input ptr_t tail, input int unsigned asize);
        return ptr_level(head, tail, asize) == (ptr_t'(1) << asize);
    endfunction

    function automatic logic ptr_empty(input ptr_t head, input ptr_t tail);
        return head == tail;
    endfunction

endpackage

// File: rtl/sync_pkt_fifo_mem.sv
// Simple dual-port RAM for the packet FIFO: synchronous write, registered write-first read with
// read enable, so the output always reflects the array contents after the same clock edge.
module sync_pkt_fifo_mem #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned ASIZE = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [0:(1<<ASIZE)-1];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_pkt_fifo.sv
// Single-clock packet FIFO with commit/rewind, abort/overflow drop and occupancy counters.
// Define SYNC_PKT_FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle read latency.
module sync_pkt_fifo
    import sync_pkt_fifo_pkg::*;
#(
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned ASIZE  = 9,
    parameter int unsigned AF_LVL = 4,
    parameter int unsigned AE_LVL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [DSIZE-1:0]      wdata,
    input  logic                  wlast,
    input  logic                  wabort,
    output logic                  wfull,
    output logic                  awfull,
    input  logic                  rinc,
    output logic [DSIZE-1:0]      rdata,
    output logic                  rlast,
    output logic                  rempty,
    output logic                  arempty,
    output logic [ASIZE:0]        level,
    output logic [ASIZE:0]        pkt_cnt,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned PTR_W = ASIZE + 1;
    localparam int unsigned DEPTH = 1 << ASIZE;

    logic [ASIZE:0]        wptr_spec_q, wptr_spec_d;
    logic [ASIZE:0]        wptr_cmt_q, wptr_cmt_d;
    logic [ASIZE:0]        rptr_q, rptr_d;
    logic [ASIZE:0]        pkt_cnt_q, pkt_cnt_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_acc, rd_acc, commit, drop;
    logic [DSIZE:0]        head_word;
    ptr_t                  used_spec, used_cmt;

    // Status flags come from registered pointers only.
    always_comb begin
        used_spec = ptr_level(ptr_t'(wptr_spec_q), ptr_t'(rptr_q), ASIZE);
        used_cmt  = ptr_level(ptr_t'(wptr_cmt_q), ptr_t'(rptr_q), ASIZE);
        wfull     = ptr_full(ptr_t'(wptr_spec_q), ptr_t'(rptr_q), ASIZE);
        rempty    = ptr_empty(ptr_t'(wptr_cmt_q), ptr_t'(rptr_q));
        awfull    = (ptr_t'(DEPTH) - used_spec) <= ptr_t'(AF_LVL);
        arempty   = used_cmt <= ptr_t'(AE_LVL);
        level     = PTR_W'(used_cmt);
    end

    always_comb begin
        wptr_spec_d = wptr_spec_q;
        wptr_cmt_d  = wptr_cmt_q;
        ovf_d       = ovf_q;
        wr_acc      = 1'b0;
        commit      = 1'b0;
        drop        = 1'b0;
        if (wabort) begin
            wptr_spec_d = wptr_cmt_q;
            ovf_d       = 1'b0;
            drop        = ovf_q || (wptr_spec_q != wptr_cmt_q);
        end else if (winc) begin
            if (ovf_q || wfull) begin
                // Once a packet overflows, swallow the rest of it and rewind at its last word.
                if (wlast) begin
                    wptr_spec_d = wptr_cmt_q;
                    ovf_d       = 1'b0;
                    drop        = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                wr_acc      = 1'b1;
                wptr_spec_d = wptr_spec_q + PTR_W'(1);
                if (wlast) begin
                    commit     = 1'b1;
                    wptr_cmt_d = wptr_spec_q + PTR_W'(1);
                end
            end
        end
    end

    always_comb begin
        rd_acc    = rinc && !rempty;
        rptr_d    = rd_acc ? rptr_q + PTR_W'(1) : rptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (commit) begin
            pkt_cnt_d = pkt_cnt_d + PTR_W'(1);
        end
        if (rd_acc && head_word[DSIZE]) begin
            pkt_cnt_d = pkt_cnt_d - PTR_W'(1);
        end
        drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + DROP_CNT_W'(1) : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_spec_q <= '0;
            wptr_cmt_q  <= '0;
            rptr_q      <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            wptr_spec_q <= wptr_spec_d;
            wptr_cmt_q  <= wptr_cmt_d;
            rptr_q      <= rptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // RAM reads at the next read pointer every cycle, so head_word is always mem[rptr_q].
    sync_pkt_fifo_mem #(
        .WIDTH (DSIZE + 1),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wptr_spec_q[ASIZE-1:0]),
        .wdata ({wlast, wdata}),
        .re    (1'b1),
        .raddr (rptr_d[ASIZE-1:0]),
        .rdata (head_word)
    );

`ifdef SYNC_PKT_FIFO_FWFT_EN
    always_comb begin
        rdata = head_word[DSIZE-1:0];
        rlast = head_word[DSIZE];
    end
`else
    logic [DSIZE:0] rword_q, rword_d;

    always_comb begin
        rword_d = rd_acc ? head_word : rword_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rword_q <= '0;
        end else begin
            rword_q <= rword_d;
        end
    end

    always_comb begin
        rdata = rword_q[DSIZE-1:0];
        rlast = rword_q[DSIZE];
    end
`endif

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Self-checking bench for sync_pkt_fifo (depth 16) using a queue-based packet model.
// Works with and without SYNC_PKT_FIFO_FWFT_EN.
module tb_sync_pkt_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 4;
    localparam int AE    = 4;

    logic        clk;
    logic        rst_n;
    logic        winc, wlast, wabort, rinc;
    logic [7:0]  wdata;
    logic        wfull, awfull, rempty, arempty, rlast;
    logic [7:0]  rdata;
    logic [4:0]  level, pkt_cnt;
    logic [15:0] drop_cnt;

    sync_pkt_fifo #(
        .DSIZE  (8),
        .ASIZE  (4),
        .AF_LVL (4),
        .AE_LVL (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .winc     (winc),
        .wdata    (wdata),
        .wlast    (wlast),
        .wabort   (wabort),
        .wfull    (wfull),
        .awfull   (awfull),
        .rinc     (rinc),
        .rdata    (rdata),
        .rlast    (rlast),
        .rempty   (rempty),
        .arempty  (arempty),
        .level    (level),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Behavioural model: committed words, pending (uncommitted) words, overflow flag, drops.
    logic [8:0] cq[$];
    logic [8:0] pq[$];
    bit         m_ovf;
    int         m_drop;
    logic [8:0] m_last_rd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit full_pre;
        if (!rst_n) begin
            cq.delete();
            pq.delete();
            m_ovf     = 0;
            m_drop    = 0;
            m_last_rd = '0;
            return;
        end
        full_pre = (cq.size() + pq.size()) == DEPTH;
        if (rinc && cq.size() > 0) m_last_rd = cq.pop_front();
        if (wabort) begin
            if ((pq.size() > 0 || m_ovf) && m_drop < 65535) m_drop++;
            pq.delete();
            m_ovf = 0;
        end else if (winc) begin
            if (m_ovf || full_pre) begin
                if (wlast) begin
                    pq.delete();
                    m_ovf = 0;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_ovf = 1;
                end
            end else begin
                pq.push_back({wlast, wdata});
                if (wlast) begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    pq.delete();
                end
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int c, p, pk;
        if (chk_en) begin
            c  = cq.size();
            p  = pq.size();
            pk = 0;
            foreach (cq[i]) if (cq[i][8]) pk++;
            check("wfull",    wfull,    (c + p) == DEPTH);
            check("awfull",   awfull,   (DEPTH - (c + p)) <= AF);
            check("rempty",   rempty,   c == 0);
            check("arempty",  arempty,  c <= AE);
            check("level",    level,    c);
            check("pkt_cnt",  pkt_cnt,  pk);
            check("drop_cnt", drop_cnt, m_drop);
`ifdef SYNC_PKT_FIFO_FWFT_EN
            if (c > 0) check("rdata_head", {rlast, rdata}, cq[0]);
`else
            check("rdata", {rlast, rdata}, m_last_rd);
`endif
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic l, input logic a, input logic r);
        winc   = w;
        wdata  = d;
        wlast  = l;
        wabort = a;
        rinc   = r;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic l);
        step(1'b1, d, l, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string nm, input logic [7:0] d, input logic l);
`ifdef SYNC_PKT_FIFO_FWFT_EN
        check(nm, {rlast, rdata}, {l, d});
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`else
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check(nm, {rlast, rdata}, {l, d});
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int len, idx, done, cyc;
        logic w, l, a, r;
        logic [7:0] d;

        winc = 0; wdata = 0; wlast = 0; wabort = 0; rinc = 0;
        do_reset();
        chk_en = 1;

        // Reset state
        check("rst_rempty",  rempty,   1);
        check("rst_arempty", arempty,  1);
        check("rst_wfull",   wfull,    0);
        check("rst_awfull",  awfull,   0);
        check("rst_level",   level,    0);
        check("rst_pkt_cnt", pkt_cnt,  0);
        check("rst_drop",    drop_cnt, 0);
        check("rst_rdata",   {rlast, rdata}, 0);

        // Commit gating
        wr(8'hA1, 0); check("cg_empty_a1", rempty, 1);
        wr(8'hA2, 0); check("cg_empty_a2", rempty, 1);
        wr(8'hA3, 1); check("cg_visible",  rempty, 0);
        check("cg_level", level, 3);
        check("cg_pkt",   pkt_cnt, 1);
        pop_check("cg_rd_a1", 8'hA1, 0);
        pop_check("cg_rd_a2", 8'hA2, 0);
        pop_check("cg_rd_a3", 8'hA3, 1);
        check("cg_pkt_after", pkt_cnt, 0);
        check("cg_empty_after", rempty, 1);

        // Abort
        do_reset();
        for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i), 0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("ab_rempty", rempty, 1);
        check("ab_level",  level, 0);
        check("ab_drop",   drop_cnt, 1);
        wr(8'hB1, 0);
        wr(8'hB2, 1);
        pop_check("ab_rd_b1", 8'hB1, 0);
        pop_check("ab_rd_b2", 8'hB2, 1);

        // Overflow of a packet longer than the depth
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr(8'h40 + 8'(i), i == 19);
            if (i == 14) check("ov_not_full15", wfull, 0);
            if (i == 15) check("ov_full16", wfull, 1);
        end
        check("ov_rempty", rempty, 1);
        check("ov_level",  level, 0);
        check("ov_drop",   drop_cnt, 1);
        check("ov_wfull",  wfull, 0);
        for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i), i == 3);
        for (int i = 0; i < 4; i++) pop_check("ov_next_pkt", 8'h60 + 8'(i), i == 3);

        // Boundaries
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr(8'h80 + 8'(i), (i % 4) == 3);
            if (i == 10) check("bd_awfull_11", awfull, 0);
            if (i == 11) check("bd_awfull_12", awfull, 1);
        end
        check("bd_wfull",  wfull, 1);
        check("bd_awfull", awfull, 1);
        check("bd_level",  level, 16);
        check("bd_pkt",    pkt_cnt, 4);
        pop_check("bd_rd_80", 8'h80, 0);
        check("bd_wfull_pop", wfull, 0);
        wr(8'hEE, 1);
        check("bd_refull", wfull, 1);
        step(1'b1, 8'hEF, 1'b1, 1'b0, 1'b1);
        check("bd_full_wr_drop",  drop_cnt, 1);
        check("bd_full_wr_level", level, 15);
        check("bd_full_wr_pkt",   pkt_cnt, 5);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("bd_drained", rempty, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("bd_empty_rinc_level", level, 0);
        check("bd_empty_rinc_pkt",   pkt_cnt, 0);
`ifndef SYNC_PKT_FIFO_FWFT_EN
        check("bd_empty_rinc_rdata", {rlast, rdata}, 9'h1EE);
`endif

        // Random packets with concurrent reads
        do_reset();
        len = $urandom_range(1, 7);
        idx = 0;
        done = 0;
        cyc = 0;
        while (done < 100 && cyc < 20000) begin
            cyc++;
            r = ($urandom_range(0, 99) < 60);
            a = (idx > 0) && ($urandom_range(0, 49) == 0);
            w = ($urandom_range(0, 9) < 8);
            d = 8'($urandom);
            l = (idx == len - 1);
            step(w, d, l, a, r);
            if (a) begin
                idx = 0;
                len = $urandom_range(1, 7);
            end else if (w) begin
                if (l) begin
                    done++;
                    idx = 0;
                    len = $urandom_range(1, 7);
                end else begin
                    idx++;
                end
            end
        end
        check("rnd_pkts_sent", done, 100);
        for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("rnd_drain_empty", rempty, 1);
        check("rnd_drain_pkt",   pkt_cnt, 0);

        // Reset mid-packet discards committed data too
        wr(8'h11, 1);
        wr(8'h12, 0);
        check("mr_level_before", level, 1);
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("mr_rempty", rempty, 1);
        check("mr_level",  level, 0);
        check("mr_pkt",    pkt_cnt, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
